// File: rtl/i2osp_stream.sv
// i2osp_stream: integer-to-octet-string conversion (PKCS#1 I2OSP) as a byte stream.
// A registered x is range-checked against 256^x_len, then x_len octets are emitted
// one per out_valid/out_ready handshake, zero-padded, most significant octet first.
// Optional macro I2OSP_LSB_FIRST_EN: emit least significant octet first instead.
module i2osp_stream #(
   parameter int unsigned DATA_BIT_WIDTH = 2048,
   parameter int unsigned LEN_W          = 12
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_BIT_WIDTH-1:0] x,
   input  logic [LEN_W-1:0]          x_len,
   output logic [7:0]                out_byte,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic                      done,
   output logic                      err
);

   localparam int unsigned NBYTES = DATA_BIT_WIDTH / 8;

   typedef enum logic [2:0] {StIdle, StCheck, StStream, StError, StFinish} state_e;

   state_e                    state_q, state_d;
   logic [DATA_BIT_WIDTH-1:0] sh_q, sh_d;
   logic [LEN_W-1:0]          len_q, len_d;
   logic [LEN_W-1:0]          rem_q, rem_d;
   logic [7:0]                out_byte_q, out_byte_d;
   logic                      in_ready_q, in_ready_d;
   logic                      out_valid_q, out_valid_d;
   logic                      out_last_q, out_last_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   logic                      too_long;
   logic                      over;
   logic [DATA_BIT_WIDTH-1:0] loaded_sh;
   logic [DATA_BIT_WIDTH-1:0] shifted_sh;

   // Octet currently at the emitting end of the shifter.
   function automatic logic [7:0] head_byte(input logic [DATA_BIT_WIDTH-1:0] v);
`ifdef I2OSP_LSB_FIRST_EN
      return v[7:0];
`else
      return v[DATA_BIT_WIDTH-1 -: 8];
`endif
   endfunction

   // Range check on the captured integer and shifter load/advance values.
   always_comb begin
      too_long = (32'(len_q) > NBYTES);
      over     = 1'b0;
      for (int i = 0; i < int'(DATA_BIT_WIDTH); i++) begin
         if (sh_q[i] && (32'(i) >= 8 * 32'(len_q))) begin
            over = 1'b1;
         end
      end
`ifdef I2OSP_LSB_FIRST_EN
      // Octet 0 already sits in the low byte; padding octets drain out last.
      loaded_sh  = sh_q;
      shifted_sh = sh_q >> 8;
`else
      // Left-align so octet x_len-1 lands in the top byte; only valid when !too_long.
      loaded_sh  = sh_q << (DATA_BIT_WIDTH - 8 * 32'(len_q));
      shifted_sh = sh_q << 8;
`endif
   end

   // Next-state logic; every output is computed here and registered below.
   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      len_d       = len_q;
      rem_d       = rem_q;
      out_byte_d  = out_byte_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sh_d       = x;
               len_d      = x_len;
               in_ready_d = 1'b0;
               state_d    = StCheck;
            end
         end
         StCheck: begin
            if (too_long || over) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = StError;
            end else if (len_q == '0) begin
               done_d  = 1'b1;
               state_d = StFinish;
            end else begin
               sh_d        = loaded_sh;
               rem_d       = len_q;
               out_valid_d = 1'b1;
               out_byte_d  = head_byte(loaded_sh);
               out_last_d  = (len_q == LEN_W'(1));
               state_d     = StStream;
            end
         end
         StStream: begin
            if (out_ready) begin
               sh_d  = shifted_sh;
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_byte_d  = 8'h00;
                  done_d      = 1'b1;
                  state_d     = StFinish;
               end else begin
                  out_byte_d = head_byte(shifted_sh);
                  out_last_d = (rem_q == LEN_W'(2));
               end
            end
         end
         StError, StFinish: begin
            in_ready_d = 1'b1;
            state_d    = StIdle;
         end
         default: begin
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_byte_d  = 8'h00;
            state_d     = StIdle;
         end
      endcase
   end

   // FSM state, datapath and registered outputs; reset abandons any stream in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         sh_q        <= '0;
         len_q       <= '0;
         rem_q       <= '0;
         out_byte_q  <= 8'h00;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         out_byte_q  <= out_byte_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_byte  = out_byte_q;
   assign out_last  = out_last_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_i2osp_stream.sv
// tb_i2osp_stream: table-driven directed test of i2osp_stream at DATA_BIT_WIDTH=32,
// plus hand-written stall and mid-stream reset sequences.
module tb_i2osp_stream;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;
   logic [3:0]  x_len;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        done;
   logic        err;

   int n_vec = 0;
   int n_bad = 0;
   int hs_cnt = 0;

   i2osp_stream #(
      .DATA_BIT_WIDTH(32),
      .LEN_W         (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x        (x),
      .x_len    (x_len),
      .out_byte (out_byte),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count output handshakes as seen at each active edge.
   always @(posedge clk) begin
      if (!reset && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
   end

   typedef struct {
      logic [31:0] vx;
      logic [3:0]  vlen;
      logic        verr;
      int          vn;
      logic [31:0] msb;  // emission order, first octet in bits [31:24]
      logic [31:0] lsb;
   } vec_t;

   vec_t tbl[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input string nm, input logic [31:0] vx, input logic [3:0] vlen,
                          input logic verr, input int vn, input logic [31:0] vexp);
      chk({nm, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      x         = vx;
      x_len     = vlen;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      x        = 32'hFFFF_FFFF;
      x_len    = 4'd1;
      chk({nm, ".check_busy"}, {31'd0, in_ready}, 32'd0);
      chk({nm, ".check_novalid"}, {31'd0, out_valid}, 32'd0);
      tick();
      if (verr) begin
         chk({nm, ".err_novalid"}, {31'd0, out_valid}, 32'd0);
         chk({nm, ".err_done"}, {31'd0, done}, 32'd1);
         chk({nm, ".err_err"}, {31'd0, err}, 32'd1);
      end else begin
         for (int i = 0; i < vn; i++) begin
            chk($sformatf("%s.valid%0d", nm, i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("%s.byte%0d", nm, i), {24'd0, out_byte}, {24'd0, vexp[31-8*i -: 8]});
            chk($sformatf("%s.last%0d", nm, i), {31'd0, out_last}, (i == vn - 1) ? 32'd1 : 32'd0);
            tick();
         end
         chk({nm, ".fin_novalid"}, {31'd0, out_valid}, 32'd0);
         chk({nm, ".fin_done"}, {31'd0, done}, 32'd1);
         chk({nm, ".fin_err"}, {31'd0, err}, 32'd0);
      end
      chk({nm, ".done_busy"}, {31'd0, in_ready}, 32'd0);
      tick();
      chk({nm, ".ready_back"}, {31'd0, in_ready}, 32'd1);
      chk({nm, ".done_pulse"}, {31'd0, done}, 32'd0);
      chk({nm, ".err_pulse"}, {31'd0, err}, 32'd0);
   endtask

   logic [31:0] exp_sel;
   logic [7:0]  st_first;
   logic [7:0]  st_second;
   int          hs_base;

   initial begin
      tbl[0]  = '{32'h00A1B2C3, 4'd4, 1'b0, 4, 32'h00A1B2C3, 32'hC3B2A100};
      tbl[1]  = '{32'h0000ABCD, 4'd2, 1'b0, 2, 32'hABCD0000, 32'hCDAB0000};
      tbl[2]  = '{32'h00010000, 4'd2, 1'b1, 0, 32'h00000000, 32'h00000000};
      tbl[3]  = '{32'h12345678, 4'd5, 1'b1, 0, 32'h00000000, 32'h00000000};
      tbl[4]  = '{32'h00000000, 4'd0, 1'b0, 0, 32'h00000000, 32'h00000000};
      tbl[5]  = '{32'h00000000, 4'd3, 1'b0, 3, 32'h00000000, 32'h00000000};
      tbl[6]  = '{32'hFFFFFFFF, 4'd4, 1'b0, 4, 32'hFFFFFFFF, 32'hFFFFFFFF};
      tbl[7]  = '{32'h000000FF, 4'd1, 1'b0, 1, 32'hFF000000, 32'hFF000000};
      tbl[8]  = '{32'h00000100, 4'd1, 1'b1, 0, 32'h00000000, 32'h00000000};
      tbl[9]  = '{32'h00000001, 4'd0, 1'b1, 0, 32'h00000000, 32'h00000000};
      tbl[10] = '{32'hDEADBEEF, 4'd3, 1'b1, 0, 32'h00000000, 32'h00000000};
      tbl[11] = '{32'h0000BEEF, 4'd3, 1'b0, 3, 32'h00BEEF00, 32'hEFBE0000};

      reset     = 1'b1;
      in_valid  = 1'b0;
      x         = '0;
      x_len     = '0;
      out_ready = 1'b0;
      #1;
      chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.out_last", {31'd0, out_last}, 32'd0);
      chk("rst.out_byte", {24'd0, out_byte}, 32'd0);
      chk("rst.done", {31'd0, done}, 32'd0);
      chk("rst.err", {31'd0, err}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      tick();

      for (int v = 0; v < 12; v++) begin
`ifdef I2OSP_LSB_FIRST_EN
         exp_sel = tbl[v].lsb;
`else
         exp_sel = tbl[v].msb;
`endif
         run_vec($sformatf("vec%0d", v), tbl[v].vx, tbl[v].vlen, tbl[v].verr, tbl[v].vn, exp_sel);
      end

      // Stall: ready 1,0,0,1 across a two-octet stream; busy in_valid is ignored.
`ifdef I2OSP_LSB_FIRST_EN
      st_first  = 8'hCD;
      st_second = 8'hAB;
`else
      st_first  = 8'hAB;
      st_second = 8'hCD;
`endif
      hs_base   = hs_cnt;
      in_valid  = 1'b1;
      x         = 32'h0000ABCD;
      x_len     = 4'd2;
      out_ready = 1'b0;
      tick();
      in_valid  = 1'b0;
      tick();
      out_ready = 1'b1;
      chk("stall.b0", {24'd0, out_byte}, {24'd0, st_first});
      chk("stall.b0_last", {31'd0, out_last}, 32'd0);
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x         = 32'hFFFFFFFF;
      x_len     = 4'd1;
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("stall.valid%0d", s), {31'd0, out_valid}, 32'd1);
         chk($sformatf("stall.b1_%0d", s), {24'd0, out_byte}, {24'd0, st_second});
         chk($sformatf("stall.last%0d", s), {31'd0, out_last}, 32'd1);
         if (s == 2) begin
            out_ready = 1'b1;
            in_valid  = 1'b0;
         end
         tick();
      end
      chk("stall.done", {31'd0, done}, 32'd1);
      chk("stall.err", {31'd0, err}, 32'd0);
      chk("stall.novalid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("stall.handshakes", 32'(hs_cnt - hs_base), 32'd2);
      chk("stall.ready_back", {31'd0, in_ready}, 32'd1);

      // Reset after the second octet of a four-octet stream.
      in_valid  = 1'b1;
      x         = 32'h00A1B2C3;
      x_len     = 4'd4;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("rstmid.valid_before", {31'd0, out_valid}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rstmid.valid_async", {31'd0, out_valid}, 32'd0);
      chk("rstmid.in_ready", {31'd0, in_ready}, 32'd1);
      chk("rstmid.done", {31'd0, done}, 32'd0);
      tick();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("rstmid.nodone%0d", c), {31'd0, done}, 32'd0);
         chk($sformatf("rstmid.novalid%0d", c), {31'd0, out_valid}, 32'd0);
      end
`ifdef I2OSP_LSB_FIRST_EN
      run_vec("after_rst", 32'h00A1B2C3, 4'd4, 1'b0, 4, 32'hC3B2A100);
`else
      run_vec("after_rst", 32'h00A1B2C3, 4'd4, 1'b0, 4, 32'h00A1B2C3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
